// File: rtl/hp_vpu_issue_queue.sv
// CV-X-IF issue/commit front end of the VPU. Accepted instructions and their scalar
// operands sit in an in-order FIFO until committed; killed entries are dropped silently.
module hp_vpu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       x_issue_valid_i,
  output logic                       x_issue_ready_o,
  input  logic [31:0]                x_issue_instr_i,
  input  logic [ID_W-1:0]            x_issue_id_i,
  input  logic [XLEN-1:0]            x_issue_rs1_i,
  input  logic [XLEN-1:0]            x_issue_rs2_i,
  input  logic                       is_vector_i,
  input  logic                       is_supported_i,
  input  logic                       is_config_i,
  output logic                       x_issue_accept_o,
  output logic                       x_issue_writeback_o,
  input  logic                       x_commit_valid_i,
  input  logic [ID_W-1:0]            x_commit_id_i,
  input  logic                       x_commit_kill_i,
  output logic                       disp_valid_o,
  input  logic                       disp_ready_i,
  output logic [31:0]                disp_instr_o,
  output logic [ID_W-1:0]            disp_id_o,
  output logic [XLEN-1:0]            disp_rs1_o,
  output logic [XLEN-1:0]            disp_rs2_o,
  output logic                       disp_is_config_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
  // valid never depends on ready; once raised, disp_valid_o and disp_* hold until taken.

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] cmt_q, cmt_d;
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [DEPTH-1:0] cfg_q, cfg_d;

  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     instr_d [DEPTH];
  logic [ID_W-1:0] id_q    [DEPTH];
  logic [ID_W-1:0] id_d    [DEPTH];
  logic [XLEN-1:0] rs1_q   [DEPTH];
  logic [XLEN-1:0] rs1_d   [DEPTH];
  logic [XLEN-1:0] rs2_q   [DEPTH];
  logic [XLEN-1:0] rs2_d   [DEPTH];

  logic full;
  logic empty;
  logic handshake;
  logic enq;
  logic pop;
  logic head_cmt;
  logic head_kill;
  logic enq_cmt_hit;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    // A config instruction only enters an empty queue so it never overtakes older work.
    x_issue_ready_o     = !rst_i && !full && !(is_config_i && !empty);
    handshake           = x_issue_valid_i && x_issue_ready_o;
    x_issue_accept_o    = handshake && is_vector_i && is_supported_i;
    x_issue_writeback_o = x_issue_accept_o && is_config_i;
    enq                 = x_issue_accept_o;

    head_cmt     = vld_q[rd_ptr_q] && cmt_q[rd_ptr_q];
    head_kill    = kill_q[rd_ptr_q];
    disp_valid_o = !rst_i && head_cmt && !head_kill;
    pop          = !rst_i && head_cmt && (head_kill || disp_ready_i);

    disp_instr_o     = instr_q[rd_ptr_q];
    disp_id_o        = id_q[rd_ptr_q];
    disp_rs1_o       = rs1_q[rd_ptr_q];
    disp_rs2_o       = rs2_q[rd_ptr_q];
    disp_is_config_o = cfg_q[rd_ptr_q];
    count_o          = count_q;
  end

  always_comb begin
    vld_d    = vld_q;
    cmt_d    = cmt_q;
    kill_d   = kill_q;
    cfg_d    = cfg_q;
    instr_d  = instr_q;
    id_d     = id_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(pop);
    enq_cmt_hit = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (x_commit_valid_i && vld_q[i] && (id_q[i] == x_commit_id_i)) begin
        cmt_d[i]  = 1'b1;
        kill_d[i] = x_commit_kill_i;
      end
    end

    if (pop) begin
      vld_d[rd_ptr_q]  = 1'b0;
      cmt_d[rd_ptr_q]  = 1'b0;
      kill_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end

    // Enqueue and pop never target the same slot: enqueue needs !full, pop needs !empty.
    if (enq) begin
      vld_d[wr_ptr_q]   = 1'b1;
      cmt_d[wr_ptr_q]   = enq_cmt_hit;
      kill_d[wr_ptr_q]  = enq_cmt_hit && x_commit_kill_i;
      cfg_d[wr_ptr_q]   = is_config_i;
      instr_d[wr_ptr_q] = x_issue_instr_i;
      id_d[wr_ptr_q]    = x_issue_id_i;
      rs1_d[wr_ptr_q]   = x_issue_rs1_i;
      rs2_d[wr_ptr_q]   = x_issue_rs2_i;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      cmt_q    <= '0;
      kill_q   <= '0;
      cfg_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      cmt_q    <= cmt_d;
      kill_q   <= kill_d;
      cfg_q    <= cfg_d;
    end
  end

  // Payload storage needs no reset; it is only observed behind a valid entry.
  always_ff @(posedge clk_i) begin
    instr_q <= instr_d;
    id_q    <= id_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
  end

endmodule

// File: tb/tb_hp_vpu_issue_queue.sv
// Directed bench for hp_vpu_issue_queue: stimulus pushes expected dispatches into a
// queue, a negedge monitor pops and compares on every dispatch transfer.
module tb_hp_vpu_issue_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ID_W  = 4;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned EW    = 32 + ID_W + XLEN + XLEN + 1;

  localparam logic [31:0] VADD    = 32'h0220_8057;
  localparam logic [31:0] VFADD   = 32'h0220_9057;
  localparam logic [31:0] VSETVLI = 32'h0D01_70D7;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            x_issue_valid_i;
  logic            x_issue_ready_o;
  logic [31:0]     x_issue_instr_i;
  logic [ID_W-1:0] x_issue_id_i;
  logic [XLEN-1:0] x_issue_rs1_i;
  logic [XLEN-1:0] x_issue_rs2_i;
  logic            is_vector_i;
  logic            is_supported_i;
  logic            is_config_i;
  logic            x_issue_accept_o;
  logic            x_issue_writeback_o;
  logic            x_commit_valid_i;
  logic [ID_W-1:0] x_commit_id_i;
  logic            x_commit_kill_i;
  logic            disp_valid_o;
  logic            disp_ready_i;
  logic [31:0]     disp_instr_o;
  logic [ID_W-1:0] disp_id_o;
  logic [XLEN-1:0] disp_rs1_o;
  logic [XLEN-1:0] disp_rs2_o;
  logic            disp_is_config_o;
  logic [$clog2(DEPTH):0] count_o;

  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  hp_vpu_issue_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .x_issue_valid_i    (x_issue_valid_i),
    .x_issue_ready_o    (x_issue_ready_o),
    .x_issue_instr_i    (x_issue_instr_i),
    .x_issue_id_i       (x_issue_id_i),
    .x_issue_rs1_i      (x_issue_rs1_i),
    .x_issue_rs2_i      (x_issue_rs2_i),
    .is_vector_i        (is_vector_i),
    .is_supported_i     (is_supported_i),
    .is_config_i        (is_config_i),
    .x_issue_accept_o   (x_issue_accept_o),
    .x_issue_writeback_o(x_issue_writeback_o),
    .x_commit_valid_i   (x_commit_valid_i),
    .x_commit_id_i      (x_commit_id_i),
    .x_commit_kill_i    (x_commit_kill_i),
    .disp_valid_o       (disp_valid_o),
    .disp_ready_i       (disp_ready_i),
    .disp_instr_o       (disp_instr_o),
    .disp_id_o          (disp_id_o),
    .disp_rs1_o         (disp_rs1_o),
    .disp_rs2_o         (disp_rs2_o),
    .disp_is_config_o   (disp_is_config_o),
    .count_o            (count_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic drive_issue(input logic [31:0] instr, input logic [ID_W-1:0] id,
                             input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                             input logic vec, input logic sup, input logic cfg);
    x_issue_valid_i = 1'b1;
    x_issue_instr_i = instr;
    x_issue_id_i    = id;
    x_issue_rs1_i   = rs1;
    x_issue_rs2_i   = rs2;
    is_vector_i     = vec;
    is_supported_i  = sup;
    is_config_i     = cfg;
  endtask

  task automatic idle_issue();
    x_issue_valid_i = 1'b0;
    is_vector_i     = 1'b0;
    is_supported_i  = 1'b0;
    is_config_i     = 1'b0;
  endtask

  task automatic drive_commit(input logic v, input logic [ID_W-1:0] id, input logic kill);
    x_commit_valid_i = v;
    x_commit_id_i    = id;
    x_commit_kill_i  = kill;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [ID_W-1:0] id,
                          input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                          input logic cfg);
    exp_q.push_back({instr, id, rs1, rs2, cfg});
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i && disp_valid_o && disp_ready_i) begin
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      act = {disp_instr_o, disp_id_o, disp_rs1_o, disp_rs2_o, disp_is_config_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dispatch_unexpected: actual id=%0h instr=%0h required=none", disp_id_o, disp_instr_o);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL dispatch: actual=%0h required=%0h", act, exp);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    disp_ready_i = 1'b1;
    x_issue_instr_i = '0;
    x_issue_id_i = '0;
    x_issue_rs1_i = '0;
    x_issue_rs2_i = '0;
    idle_issue();
    drive_commit(1'b0, '0, 1'b0);

    // 1: reset
    repeat (3) tick();
    at_neg();
    check("rst_count", 64'(count_o), 0);
    check("rst_ready", 64'(x_issue_ready_o), 0);
    check("rst_disp_valid", 64'(disp_valid_o), 0);
    tick();
    rst_i = 1'b0;
    at_neg();
    check("post_rst_ready", 64'(x_issue_ready_o), 1);

    // 2: issue with same-cycle commit, dispatch next cycle
    tick();
    drive_issue(VADD, 4'd1, 32'hA5, 32'h5A, 1'b1, 1'b1, 1'b0);
    drive_commit(1'b1, 4'd1, 1'b0);
    push_exp(VADD, 4'd1, 32'hA5, 32'h5A, 1'b0);
    at_neg();
    check("t2_accept", 64'(x_issue_accept_o), 1);
    check("t2_writeback", 64'(x_issue_writeback_o), 0);
    tick();
    idle_issue();
    drive_commit(1'b0, '0, 1'b0);
    at_neg();
    check("t2_disp_valid", 64'(disp_valid_o), 1);
    check("t2_disp_id", 64'(disp_id_o), 1);
    check("t2_disp_rs1", 64'(disp_rs1_o), 64'hA5);
    tick();
    at_neg();
    check("t2_count", 64'(count_o), 0);

    // 3: unsupported FP op completes handshake without enqueue
    tick();
    drive_issue(VFADD, 4'd2, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    at_neg();
    check("t3_ready", 64'(x_issue_ready_o), 1);
    check("t3_accept", 64'(x_issue_accept_o), 0);
    tick();
    idle_issue();
    at_neg();
    check("t3_count", 64'(count_o), 0);

    // 4: fill, then full-to-ready latency after one dispatch
    disp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_issue(VADD, ID_W'(i), 32'h10 + 32'(i), 32'h20 + 32'(i), 1'b1, 1'b1, 1'b0);
      push_exp(VADD, ID_W'(i), 32'h10 + 32'(i), 32'h20 + 32'(i), 1'b0);
    end
    tick();
    idle_issue();
    drive_commit(1'b1, 4'd0, 1'b0);
    disp_ready_i = 1'b1;
    at_neg();
    check("t4_count_full", 64'(count_o), 4);
    check("t4_ready_full", 64'(x_issue_ready_o), 0);
    tick();
    drive_commit(1'b0, '0, 1'b0);
    at_neg();
    check("t4_disp_valid", 64'(disp_valid_o), 1);
    check("t4_ready_same_cycle", 64'(x_issue_ready_o), 0);
    tick();
    at_neg();
    check("t4_ready_next", 64'(x_issue_ready_o), 1);
    check("t4_count_3", 64'(count_o), 3);
    for (int j = 1; j < 4; j++) begin
      tick();
      drive_commit(1'b1, ID_W'(j), 1'b0);
    end
    tick();
    drive_commit(1'b0, '0, 1'b0);
    repeat (4) tick();
    at_neg();
    check("t4_drained", 64'(count_o), 0);

    // 5: killed entry after pointer wrap is dropped silently
    tick();
    drive_issue(VADD, 4'd3, 32'h33, 32'h44, 1'b1, 1'b1, 1'b0);
    drive_commit(1'b1, 4'd3, 1'b1);
    at_neg();
    check("t5_accept", 64'(x_issue_accept_o), 1);
    tick();
    idle_issue();
    drive_commit(1'b0, '0, 1'b0);
    at_neg();
    check("t5_count_1", 64'(count_o), 1);
    check("t5_disp_valid", 64'(disp_valid_o), 0);
    tick();
    at_neg();
    check("t5_count_0", 64'(count_o), 0);

    // 6: config waits for an empty queue
    tick();
    drive_issue(VADD, 4'd7, 32'h77, 32'h78, 1'b1, 1'b1, 1'b0);
    push_exp(VADD, 4'd7, 32'h77, 32'h78, 1'b0);
    tick();
    drive_issue(VSETVLI, 4'd8, 32'h80, 32'h0, 1'b1, 1'b1, 1'b1);
    at_neg();
    check("t6_cfg_ready", 64'(x_issue_ready_o), 0);
    check("t6_cfg_accept", 64'(x_issue_accept_o), 0);
    tick();
    at_neg();
    check("t6_cfg_ready_hold", 64'(x_issue_ready_o), 0);
    tick();
    drive_commit(1'b1, 4'd7, 1'b0);
    at_neg();
    check("t6_ready_at_commit", 64'(x_issue_ready_o), 0);
    tick();
    drive_commit(1'b0, '0, 1'b0);
    at_neg();
    check("t6_head_disp", 64'(disp_valid_o), 1);
    check("t6_ready_during_disp", 64'(x_issue_ready_o), 0);
    tick();
    drive_commit(1'b1, 4'd8, 1'b0);
    push_exp(VSETVLI, 4'd8, 32'h80, 32'h0, 1'b1);
    at_neg();
    check("t6_ready_empty", 64'(x_issue_ready_o), 1);
    check("t6_accept", 64'(x_issue_accept_o), 1);
    check("t6_writeback", 64'(x_issue_writeback_o), 1);
    tick();
    idle_issue();
    drive_commit(1'b0, '0, 1'b0);
    at_neg();
    check("t6_cfg_disp_valid", 64'(disp_valid_o), 1);
    check("t6_cfg_flag", 64'(disp_is_config_o), 1);
    tick();
    at_neg();
    check("t6_count", 64'(count_o), 0);

    // reset mid-operation discards a committed entry
    disp_ready_i = 1'b0;
    tick();
    drive_issue(VADD, 4'd9, 32'h99, 32'h9A, 1'b1, 1'b1, 1'b0);
    drive_commit(1'b1, 4'd9, 1'b0);
    tick();
    idle_issue();
    drive_commit(1'b0, '0, 1'b0);
    at_neg();
    check("mr_disp_valid_pre", 64'(disp_valid_o), 1);
    tick();
    rst_i = 1'b1;
    at_neg();
    check("mr_disp_valid_rst", 64'(disp_valid_o), 0);
    check("mr_ready_rst", 64'(x_issue_ready_o), 0);
    tick();
    rst_i = 1'b0;
    at_neg();
    check("mr_count", 64'(count_o), 0);
    check("mr_disp_valid_post", 64'(disp_valid_o), 0);

    repeat (3) tick();
    check("exp_q_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
